// File: rtl/traffic_pkg.sv
// traffic_pkg: phase encoding, lamp codes and width helper shared by the intersection controller.
package traffic_pkg;
  typedef enum logic [2:0] {GREEN, YELLOW, CLEAR, WALK, CLEAR2, FLASH} phase_e;
  localparam logic [2:0] LAMP_G   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_R   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;
  function automatic int dir_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every CLK_FREQ/TICK_HZ cycles, with sync clear.
module tick_gen #(
  parameter int CLK_FREQ = 125_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
  localparam int W = $clog2(TICK_CYC);
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(TICK_CYC - 1);
  always_ff @(posedge clk) cnt_q <= (rst || clr || tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: rotates right-of-way over NUM_DIR approaches with clearance, pedestrian walk and night flash.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int TICK_HZ  = 1,
  parameter int NUM_DIR  = 2,
  parameter int CNT_W    = 4,
  parameter int GREEN_T  = 9,
  parameter int YELLOW_T = 3,
  parameter int CLEAR_T  = 1,
  parameter int WALK_T   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ped_btn,
  input  logic                          night,
  output logic [3*NUM_DIR-1:0]          car_light,
  output logic                          walk,
  output logic                          ped_pending,
  output logic [CNT_W-1:0]              countdown,
  output logic [dir_w(NUM_DIR)-1:0]     cur_dir,
  output logic                          tick
);
  localparam int DW = dir_w(NUM_DIR);
  localparam int T_MAX = (1 << CNT_W) - 1;
  if (GREEN_T < 1 || GREEN_T > T_MAX || YELLOW_T < 1 || YELLOW_T > T_MAX ||
      CLEAR_T < 1 || CLEAR_T > T_MAX || WALK_T < 1 || WALK_T > T_MAX ||
      CLK_FREQ / TICK_HZ < 2 || NUM_DIR < 2 || NUM_DIR > 8) begin : g_bad_param
    $error("traffic_intersection_ctrl: illegal parameter set");
  end
  phase_e               state_q, state_d;
  logic [DW-1:0]        dir_q, dir_d, dir_inc;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ped_q, ped_d, flash_q, flash_d, ff_q, ff_d, walk_q, tick_q, tick_w;
  logic [3*NUM_DIR-1:0] light_q, light_d;
  tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk(clk), .rst(rst), .clr(state_d != state_q), .tick(tick_w)
  );
  assign dir_inc = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;
  // ff_q marks the clearance that follows FLASH, which restarts rotation at approach 0
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    ff_d    = ff_q;
    ped_d   = ped_q | (ped_btn && state_q != WALK);
    if (state_q == FLASH) begin
      ped_d = 1'b0;
      if (tick_w) begin
        flash_d = ~flash_q;
        if (!night) begin
          state_d = CLEAR;
          cnt_d   = CNT_W'(CLEAR_T);
          dir_d   = '0;
          ff_d    = 1'b1;
        end
      end
    end else if (tick_w && cnt_q != CNT_W'(1)) begin
      cnt_d = cnt_q - 1'b1;
    end else if (tick_w) begin
      case (state_q)
        GREEN:  begin state_d = YELLOW; cnt_d = CNT_W'(YELLOW_T); end
        YELLOW: begin state_d = CLEAR;  cnt_d = CNT_W'(CLEAR_T);  end
        WALK:   begin state_d = CLEAR2; cnt_d = CNT_W'(CLEAR_T);  end
        default: begin
          ff_d = 1'b0;
          if (night) begin
            state_d = FLASH;
            cnt_d   = '0;
            flash_d = 1'b0;
            ped_d   = 1'b0;
          end else if (state_q == CLEAR && ped_d) begin
            state_d = WALK;
            cnt_d   = CNT_W'(WALK_T);
            ped_d   = 1'b0;
          end else begin
            state_d = GREEN;
            cnt_d   = CNT_W'(GREEN_T);
            dir_d   = ff_q ? dir_q : dir_inc;
          end
        end
      endcase
    end
  end
  always_comb begin
    light_d = '0;
    for (int d = 0; d < NUM_DIR; d++)
      light_d[3*d +: 3] = (state_d == FLASH) ? (flash_d ? LAMP_Y : LAMP_OFF) :
                          ((state_d == GREEN || state_d == YELLOW) && dir_d == DW'(d)) ?
                          ((state_d == GREEN) ? LAMP_G : LAMP_Y) : LAMP_R;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GREEN;
      dir_q   <= '0;
      cnt_q   <= CNT_W'(GREEN_T);
      ped_q   <= 1'b0;
      flash_q <= 1'b0;
      ff_q    <= 1'b0;
      walk_q  <= 1'b0;
      tick_q  <= 1'b0;
      light_q <= {{(NUM_DIR-1){LAMP_R}}, LAMP_G};
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      flash_q <= flash_d;
      ff_q    <= ff_d;
      walk_q  <= state_d == WALK;
      tick_q  <= tick_w;
      light_q <= light_d;
    end
  end
  assign car_light   = light_q;
  assign walk        = walk_q;
  assign ped_pending = ped_q;
  assign countdown   = cnt_q;
  assign cur_dir     = dir_q;
  assign tick        = tick_q;
endmodule
